tx_chip_gen: RTL and testbench

Transmit-side chip timing generator for the O-QPSK baseband path; it is the transmit counterpart of the CDR sampling counter. It accepts 4-bit data symbols over a valid/ready handshake and maps each one to its 32-chip IEEE 802.15.4 (2.4 GHz) spreading sequence. It then shifts the chips out serially, holding each chip for a programmable number of clock cycles. The output feeds the transmit modulator and reuses the same clocks-per-chip convention as the receive CDR.

---
 rtl/tx_chip_gen.sv | 139 +++++++++++++
 tb/tb_tx_chip_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_chip_gen.sv
// tx_chip_gen: transmit chip timing generator for the 802.15.4 O-QPSK path.
// Takes 4-bit symbols over valid/ready, expands each to its 32-chip sequence
// and shifts the chips out c0 first, each chip held for nb clocks.
//
// state | meaning
// IDLE  | nothing in flight, o_chip held low, waiting for the hold register
// SEND  | shifting out the 32 chips of the current symbol
module tx_chip_gen #(
   parameter int unsigned NB_P_MIN = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_nb_P,
   input  logic [3:0] i_sym,
   input  logic       i_sym_valid,
   output logic       o_sym_ready,
   output logic       o_chip,
   output logic       o_chip_en,
   output logic       o_sym_done,
   output logic       o_busy
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   // Symbol 0 written as a string: c0 is the MSB, c31 the LSB.
   localparam logic [31:0] SEQ0   = 32'b1101_1001_1100_0011_0101_0010_0010_1110;
   localparam logic [5:0]  NB_MIN = 6'(NB_P_MIN);

   // Returns the chip sequence with chip i at bit i, so shifter[0] is the
   // chip on air. Symbols 1-7 rotate symbol 0 right by 4 chips per step;
   // the upper half inverts the odd-indexed chips.
   function automatic logic [31:0] chip_map(input logic [3:0] sym);
      logic [31:0] seq;
      logic [4:0]  src;
      seq = '0;
      for (int i = 0; i < 32; i++) begin
         src    = 5'(i) - {sym[2:0], 2'b00};
         seq[i] = SEQ0[5'd31 - src] ^ (sym[3] & i[0]);
      end
      return seq;
   endfunction

   state_t      state_q, state_d;
   logic        hold_full_q, hold_full_d;
   logic [3:0]  hold_sym_q, hold_sym_d;
   logic [31:0] shifter_q, shifter_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [5:0]  nb_q, nb_d;
   logic [4:0]  idx_q, idx_d;

   logic        chip_last;
   logic        sym_last;
   logic        accept;
   logic        load;
   logic [5:0]  nb_load;

   assign chip_last = (state_q == SEND) && (cnt_q == nb_q - 6'd1);
   assign sym_last  = chip_last && (idx_q == 5'd31);
   // Ready is low while hold_full is set, so accept and load never coincide.
   assign accept    = i_sym_valid && !hold_full_q;
   assign load      = hold_full_q && ((state_q == IDLE) || sym_last);
   assign nb_load   = (i_nb_P < NB_MIN) ? NB_MIN : i_nb_P;

   // State registers, cleared asynchronously; reset drops any held symbol.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         hold_sym_q  <= '0;
         shifter_q   <= '0;
         cnt_q       <= '0;
         nb_q        <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_sym_q  <= hold_sym_d;
         shifter_q   <= shifter_d;
         cnt_q       <= cnt_d;
         nb_q        <= nb_d;
         idx_q       <= idx_d;
      end
   end

   // Next-state logic: chip timing, shifting, gapless reload and handshake.
   always_comb begin
      state_d     = state_q;
      hold_full_d = hold_full_q;
      hold_sym_d  = hold_sym_q;
      shifter_d   = shifter_q;
      cnt_d       = cnt_q;
      nb_d        = nb_q;
      idx_d       = idx_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
         end
         SEND: begin
            if (chip_last) begin
               cnt_d     = '0;
               shifter_d = {1'b0, shifter_q[31:1]};
               idx_d     = idx_q + 5'd1;
               if (idx_q == 5'd31) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A load overrides the end-of-symbol return to IDLE, giving
      // back-to-back symbols with no idle cycle.
      if (load) begin
         state_d     = SEND;
         shifter_d   = chip_map(hold_sym_q);
         nb_d        = nb_load;
         cnt_d       = '0;
         idx_d       = '0;
         hold_full_d = 1'b0;
      end

      if (accept) begin
         hold_full_d = 1'b1;
         hold_sym_d  = i_sym;
      end
   end

   assign o_sym_ready = !hold_full_q;
   assign o_busy      = (state_q == SEND);
   assign o_chip      = (state_q == SEND) && shifter_q[0];
   assign o_chip_en   = (state_q == SEND) && (cnt_q == 6'd0);
   assign o_sym_done  = sym_last;

endmodule

// File: tb/tb_tx_chip_gen.sv
// tb_tx_chip_gen: table-driven and randomized bench for tx_chip_gen with a
// time-based reference model (one position counter per symbol, chip index
// and strobes derived by division and modulo).
module tb_tx_chip_gen;

   localparam int NB_P_MIN = 4;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic [5:0] i_nb_P = 6'd4;
   logic [3:0] i_sym = 4'd0;
   logic       i_sym_valid = 1'b0;
   logic       o_sym_ready, o_chip, o_chip_en, o_sym_done, o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   tx_chip_gen #(.NB_P_MIN(NB_P_MIN)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_nb_P      (i_nb_P),
      .i_sym       (i_sym),
      .i_sym_valid (i_sym_valid),
      .o_sym_ready (o_sym_ready),
      .o_chip      (o_chip),
      .o_chip_en   (o_chip_en),
      .o_sym_done  (o_sym_done),
      .o_busy      (o_busy)
   );

   // Standard 802.15.4 2.4 GHz chip table, c0 leftmost.
   function automatic logic [31:0] ref_seq(input logic [3:0] s);
      case (s)
         4'd0:    return 32'b1101_1001_1100_0011_0101_0010_0010_1110;
         4'd1:    return 32'b1110_1101_1001_1100_0011_0101_0010_0010;
         4'd2:    return 32'b0010_1110_1101_1001_1100_0011_0101_0010;
         4'd3:    return 32'b0010_0010_1110_1101_1001_1100_0011_0101;
         4'd4:    return 32'b0101_0010_0010_1110_1101_1001_1100_0011;
         4'd5:    return 32'b0011_0101_0010_0010_1110_1101_1001_1100;
         4'd6:    return 32'b1100_0011_0101_0010_0010_1110_1101_1001;
         4'd7:    return 32'b1001_1100_0011_0101_0010_0010_1110_1101;
         4'd8:    return 32'b1000_1100_1001_0110_0000_0111_0111_1011;
         4'd9:    return 32'b1011_1000_1100_1001_0110_0000_0111_0111;
         4'd10:   return 32'b0111_1011_1000_1100_1001_0110_0000_0111;
         4'd11:   return 32'b0111_0111_1011_1000_1100_1001_0110_0000;
         4'd12:   return 32'b0000_0111_0111_1011_1000_1100_1001_0110;
         4'd13:   return 32'b0110_0000_0111_0111_1011_1000_1100_1001;
         4'd14:   return 32'b1001_0110_0000_0111_0111_1011_1000_1100;
         default: return 32'b1100_1001_0110_0000_0111_0111_1011_1000;
      endcase
   endfunction

   function automatic logic ref_chip(input logic [3:0] s, input int i);
      logic [31:0] w;
      w = ref_seq(s);
      return w[31 - i];
   endfunction

   // Reference model state
   bit         m_hold_full;
   logic [3:0] m_hold_sym;
   bit         m_active;
   logic [3:0] m_sym;
   int         m_nb;
   int         m_t;
   bit         m_accept;

   task automatic model_reset();
      m_hold_full = 0;
      m_hold_sym  = '0;
      m_active    = 0;
      m_sym       = '0;
      m_nb        = NB_P_MIN;
      m_t         = 0;
      m_accept    = 0;
   endtask

   task automatic model_step();
      bit end_sym;
      m_accept = i_sym_valid && !m_hold_full;
      end_sym  = m_active && (m_t == 32 * m_nb - 1);
      if (m_active && !end_sym) begin
         m_t++;
      end else if (m_hold_full) begin
         m_sym       = m_hold_sym;
         m_nb        = (int'(i_nb_P) < NB_P_MIN) ? NB_P_MIN : int'(i_nb_P);
         m_t         = 0;
         m_active    = 1;
         m_hold_full = 0;
      end else begin
         m_active = 0;
      end
      if (m_accept) begin
         m_hold_full = 1;
         m_hold_sym  = i_sym;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_outputs();
      logic e_chip, e_en, e_done;
      e_chip = 1'b0;
      e_en   = 1'b0;
      e_done = 1'b0;
      if (m_active) begin
         e_chip = ref_chip(m_sym, m_t / m_nb);
         e_en   = ((m_t % m_nb) == 0);
         e_done = (m_t == 32 * m_nb - 1);
      end
      check("o_sym_ready", 32'(o_sym_ready), 32'(!m_hold_full));
      check("o_busy",      32'(o_busy),      32'(m_active));
      check("o_chip",      32'(o_chip),      32'(e_chip));
      check("o_chip_en",   32'(o_chip_en),   32'(e_en));
      check("o_sym_done",  32'(o_sym_done),  32'(e_done));
   endtask

   // One clock: model advances on the same edge, outputs compared 1 ns later.
   task automatic cycle();
      @(posedge i_clk);
      if (i_rst) model_reset();
      else       model_step();
      #1;
      check_outputs();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((o_busy || !o_sym_ready) && n < 3000) begin
         cycle();
         n++;
      end
      check("idle wait", 32'(o_busy || !o_sym_ready), 32'd0);
   endtask

   typedef struct {
      logic [3:0] sym;
      logic [5:0] nb;
      int         len;
      logic [7:0] first8;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v);
      int first, done_at, nce;
      logic [7:0] cap;
      first = -1; done_at = -1; nce = 0; cap = '0;
      wait_idle();
      i_sym = v.sym; i_nb_P = v.nb; i_sym_valid = 1'b1;
      cycle();
      i_sym_valid = 1'b0;
      for (int k = 0; k < 2100 && done_at < 0; k++) begin
         cycle();
         if (o_chip_en) begin
            if (first < 0) first = k;
            if (nce < 8) cap = {cap[6:0], o_chip};
            nce++;
         end
         if (o_sym_done) done_at = k;
      end
      check("vec first chip latency", 32'(first), 32'd0);
      check("vec symbol length", 32'(done_at - first + 1), 32'(v.len));
      check("vec first 8 chips", 32'(cap), 32'(v.first8));
      check("vec chip_en count", 32'(nce), 32'd32);
      cycle();
      check("vec back to idle", 32'(o_busy), 32'd0);
      check("vec idle chip low", 32'(o_chip), 32'd0);
   endtask

   initial begin
      int first, last, acc3, k, dones, f1, d1, d2, nce, n;
      logic [3:0] seq3 [3];
      logic [3:0] acc;
      logic [31:0] cap32;

      vecs[0] = '{sym: 4'd0,  nb: 6'd4,  len: 128,  first8: 8'b1101_1001};
      vecs[1] = '{sym: 4'd7,  nb: 6'd5,  len: 160,  first8: 8'b1001_1100};
      vecs[2] = '{sym: 4'd8,  nb: 6'd63, len: 2016, first8: 8'b1000_1100};
      vecs[3] = '{sym: 4'd15, nb: 6'd7,  len: 224,  first8: 8'b1100_1001};
      vecs[4] = '{sym: 4'd3,  nb: 6'd0,  len: 128,  first8: 8'b0010_0010};
      vecs[5] = '{sym: 4'd12, nb: 6'd2,  len: 128,  first8: 8'b0000_0111};

      model_reset();
      #2 i_rst = 1'b1;
      #1 check_outputs();
      cycle();
      cycle();
      i_rst = 1'b0;
      cycle();
      cycle();

      // single symbols, clamp and long chips
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // gapless streaming of 0, 7, 15 with valid held high
      wait_idle();
      seq3[0] = 4'd0; seq3[1] = 4'd7; seq3[2] = 4'd15;
      i_nb_P = 6'd8; i_sym = seq3[0]; i_sym_valid = 1'b1;
      k = 0; dones = 0; first = -1; last = -1; acc3 = -1;
      for (int c = 0; c < 900 && dones < 3; c++) begin
         cycle();
         if (m_accept) begin
            k++;
            if (k == 3) acc3 = c;
            if (k < 3) i_sym = seq3[k];
            else       i_sym_valid = 1'b0;
         end
         if (o_chip_en && first < 0) first = c;
         if (o_sym_done) begin dones++; last = c; end
      end
      check("stream done count", 32'(dones), 32'd3);
      check("stream total span", 32'(last - first + 1), 32'd768);
      check("stream third accept", 32'(acc3 - first), 32'd257);

      // nb latched at load: change 6 -> 10 at chip 5
      wait_idle();
      i_nb_P = 6'd6; i_sym = 4'd2; i_sym_valid = 1'b1;
      cycle();
      i_sym_valid = 1'b0;
      nce = 0; f1 = -1; d1 = -1; d2 = -1;
      for (int c = 0; c < 900 && d2 < 0; c++) begin
         cycle();
         if (m_accept) i_sym_valid = 1'b0;
         if (o_chip_en) begin
            if (f1 < 0) f1 = c;
            nce++;
            if (nce == 6) begin
               i_nb_P = 6'd10; i_sym = 4'd5; i_sym_valid = 1'b1;
            end
         end
         if (o_sym_done) begin
            if (d1 < 0) d1 = c;
            else        d2 = c;
         end
      end
      check("latch first symbol length", 32'(d1 - f1 + 1), 32'd192);
      check("latch second symbol length", 32'(d2 - d1), 32'd320);

      // asynchronous reset 40 cycles into a symbol with the hold register full
      wait_idle();
      i_nb_P = 6'd4; i_sym = 4'd1; i_sym_valid = 1'b1;
      cycle();
      i_sym = 4'd9;
      n = 0;
      do begin cycle(); n++; end while (!m_accept && n < 10);
      i_sym_valid = 1'b0;
      check("reset setup hold full", 32'(o_sym_ready), 32'd0);
      n = 0;
      while (m_t != 39 && n < 200) begin cycle(); n++; end
      #2 i_rst = 1'b1;
      #1 model_reset();
      check_outputs();
      cycle();
      cycle();
      i_rst = 1'b0;
      nce = 0;
      for (int c = 0; c < 60; c++) begin
         cycle();
         if (o_chip_en || o_busy) nce++;
      end
      check("no chips after reset", 32'(nce), 32'd0);

      // valid without ready: i_sym wanders while the hold register is full
      wait_idle();
      i_nb_P = 6'd4; i_sym = 4'd0; i_sym_valid = 1'b1;
      cycle();
      i_sym = 4'd4;
      n = 0;
      do begin cycle(); n++; end while (!m_accept && n < 10);
      acc = '0;
      n = 0;
      do begin
         i_sym = 4'($urandom_range(0, 15));
         acc = i_sym;
         cycle();
         n++;
      end while (!m_accept && n < 300);
      i_sym_valid = 1'b0;
      dones = 0; cap32 = '0;
      for (int c = 0; c < 800 && dones < 2; c++) begin
         cycle();
         if (o_chip_en && dones == 1) cap32 = {cap32[30:0], o_chip};
         if (o_sym_done) dones++;
      end
      check("stalled symbol done count", 32'(dones), 32'd2);
      check("stalled symbol chips", cap32, ref_seq(acc));

      // randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         i_sym_valid = ($urandom_range(0, 9) < 4);
         i_sym       = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) i_nb_P = 6'($urandom_range(0, 9));
         cycle();
      end
      i_sym_valid = 1'b0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
